ex_hilo: RTL and testbench
==========================

EX_HILO -- requirements
Module: ex_hilo

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: stall_i  input  1  hold EX/MEM register and HI/LO this cycle.
REQ-004 SHALL have port: flush_i  input  1  load a bubble into the EX/MEM register.
REQ-005 SHALL have port: aluop_i  input  8  operation code from ID/EX.
REQ-006 SHALL have port: alusel_i  input  3  result class from ID/EX.
REQ-007 SHALL have ports: reg1_i, reg2_i  input  32  source operands; reg1_i already carries the immediate or shamt where ID selected one.
REQ-008 SHALL have ports: wd_i  input  5  destination; wreg_i  input  1  write enable.
REQ-009 SHALL have ports: ex_wreg_o 1, ex_wd_o 5, ex_wdata_o 32  output  combinational EX result, fed back to ID for forwarding.
REQ-010 SHALL have ports: mem_wreg_o 1, mem_wd_o 5, mem_wdata_o 32  output  registered EX/MEM result.
REQ-011 SHALL have ports: hi_o, lo_o  output  32  current HI/LO register contents.

Function
REQ-012 Encodings SHALL be: aluop AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLL 0x7C, SRL 0x02, SRA 0x03, MOVZ 0x0A, MOVN 0x0B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, NOP 0x00; alusel NOP 0, LOGIC 1, SHIFT 2, MOVE 3.
REQ-013 LOGIC result SHALL be the bitwise AND/OR/XOR/NOR of reg1_i and reg2_i, as selected by aluop_i.
REQ-014 SHIFT result SHALL be reg2_i shifted by reg1_i[4:0]: SLL logical left, SRL logical right, SRA arithmetic right (sign fill from reg2_i[31]).
REQ-015 MOVE result SHALL be HI for MFHI, LO for MFLO, and reg1_i for MOVZ/MOVN; the write decision SHALL be taken from wreg_i unchanged.
REQ-016 ex_wdata_o SHALL be the result selected by alusel_i, and 0 for NOP or any undefined alusel/aluop pair; ex_wreg_o = wreg_i; ex_wd_o = wd_i.
REQ-017 ex_* outputs SHALL be purely combinational, with zero-cycle latency, and SHALL remain valid while stall_i is high.
REQ-018 On each rising edge with rst=0, flush_i=0 and stall_i=0, mem_* SHALL capture ex_*, giving 1-cycle latency.
REQ-019 The HI register SHALL take reg1_i on the same edge that an MTHI (aluop 0x11) is captured by REQ-018; MTLO SHALL update LO in the same way; alusel_i and wreg_i SHALL be ignored for these two ops.
REQ-020 An MFHI/MFLO in EX on the cycle after an MTHI/MTLO commits SHALL read the new value, with no hazard bubble.
REQ-021 stall_i=1 SHALL hold mem_*, HI and LO unchanged.
REQ-022 flush_i=1 SHALL load mem_wreg_o=0, mem_wd_o=0, mem_wdata_o=0 and SHALL suppress any HI/LO write.
REQ-023 Priority SHALL be rst > flush_i > stall_i, so that flush_i together with stall_i produces a bubble.

Reset
REQ-024 With rst=1 at a rising edge, mem_wreg_o, mem_wd_o, mem_wdata_o, HI and LO SHALL all become 0.
REQ-025 While rst=1, ex_wreg_o=0, ex_wd_o=0 and ex_wdata_o=0.
REQ-026 Reset asserted mid-sequence, including alongside a pending MTHI, SHALL discard that write.

Configuration
REQ-027 Macro MOVE_OP_EN: when defined, the block SHALL implement the HI/LO registers and MFHI/MFLO/MTHI/MTLO as above.
REQ-028 When MOVE_OP_EN is undefined: no HI/LO storage; hi_o=lo_o=0; MFHI/MFLO results = 0 with ex_wreg_o forced to 0; MTHI/MTLO = NOP; MOVZ/MOVN still supported.

Verification
REQ-029 ORI-style stimulus: alusel=1, aluop=0x25, reg1=0x0000FFFF, reg2=0xFF000000, wd=3, wreg=1 -> ex_wdata_o=0xFF00FFFF same cycle; mem_wdata_o=0xFF00FFFF, mem_wd_o=3 next cycle.
REQ-030 SRA: reg1=4, reg2=0x80000000 -> result 0xF8000000; SRL with the same operands -> 0x08000000; SLL with reg1=31, reg2=1 -> 0x80000000.
REQ-031 MTHI with reg1=0x12345678, then MFHI wd=5 wreg=1 in the next cycle -> hi_o=0x12345678 and MFHI ex_wdata_o=0x12345678.
REQ-032 MTLO with reg1=0xA5A5A5A5 while stall_i=1 for 2 cycles -> LO stays 0; after stall_i drops -> LO=0xA5A5A5A5 and mem_* unchanged throughout the stall.
REQ-033 flush_i=1 and stall_i=1 while MTHI reg1=0xDEAD0000 is in EX -> mem_wreg_o=0, mem_wdata_o=0, HI unchanged.
REQ-034 rst=1 for one cycle after HI=0x1 -> hi_o=0 and all mem_* = 0; MOVE_OP_EN undefined build: MFHI wreg=1 -> ex_wreg_o=0, ex_wdata_o=0.

Source files
------------

// File: rtl/ex_hilo.sv
// EX stage with EX/MEM pipeline register and optional HI/LO special registers.
// Define MOVE_OP_EN to build HI/LO storage and the MFHI/MFLO/MTHI/MTLO operations.
module ex_hilo (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [7:0]  aluop_i,
   input  logic [2:0]  alusel_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   output logic        ex_wreg_o,
   output logic [4:0]  ex_wd_o,
   output logic [31:0] ex_wdata_o,
   output logic        mem_wreg_o,
   output logic [4:0]  mem_wd_o,
   output logic [31:0] mem_wdata_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);

   localparam logic [7:0] OP_AND  = 8'h24;
   localparam logic [7:0] OP_OR   = 8'h25;
   localparam logic [7:0] OP_XOR  = 8'h26;
   localparam logic [7:0] OP_NOR  = 8'h27;
   localparam logic [7:0] OP_SLL  = 8'h7C;
   localparam logic [7:0] OP_SRL  = 8'h02;
   localparam logic [7:0] OP_SRA  = 8'h03;
   localparam logic [7:0] OP_MOVZ = 8'h0A;
   localparam logic [7:0] OP_MOVN = 8'h0B;
   localparam logic [7:0] OP_MFHI = 8'h10;
   localparam logic [7:0] OP_MTHI = 8'h11;
   localparam logic [7:0] OP_MFLO = 8'h12;
   localparam logic [7:0] OP_MTLO = 8'h13;

   typedef enum logic [2:0] {
      SEL_NOP   = 3'd0,
      SEL_LOGIC = 3'd1,
      SEL_SHIFT = 3'd2,
      SEL_MOVE  = 3'd3
   } alusel_e;

   // A pipeline slot advances only when neither flushed nor stalled.
   logic advance;
   assign advance = !flush_i && !stall_i;

`ifdef MOVE_OP_EN
   logic [31:0] hi;
   logic [31:0] lo;

   // MTHI/MTLO commit on the same edge the op leaves EX, so a following MFHI/MFLO
   // reads the new value straight from the register without a bypass.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (advance) begin
         if (aluop_i == OP_MTHI) hi <= reg1_i;
         if (aluop_i == OP_MTLO) lo <= reg1_i;
      end
   end

   assign hi_o = hi;
   assign lo_o = lo;
`else
   assign hi_o = '0;
   assign lo_o = '0;
`endif

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      ex_wdata_o = '0;
      ex_wreg_o  = wreg_i;
      ex_wd_o    = wd_i;

      case (alusel_e'(alusel_i))
         SEL_LOGIC: begin
            case (aluop_i)
               OP_AND:  ex_wdata_o = reg1_i & reg2_i;
               OP_OR:   ex_wdata_o = reg1_i | reg2_i;
               OP_XOR:  ex_wdata_o = reg1_i ^ reg2_i;
               OP_NOR:  ex_wdata_o = ~(reg1_i | reg2_i);
               default: ex_wdata_o = '0;
            endcase
         end
         SEL_SHIFT: begin
            case (aluop_i)
               OP_SLL:  ex_wdata_o = reg2_i << reg1_i[4:0];
               OP_SRL:  ex_wdata_o = reg2_i >> reg1_i[4:0];
               OP_SRA:  ex_wdata_o = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
               default: ex_wdata_o = '0;
            endcase
         end
         SEL_MOVE: begin
            case (aluop_i)
               OP_MOVZ, OP_MOVN: ex_wdata_o = reg1_i;
`ifdef MOVE_OP_EN
               OP_MFHI:          ex_wdata_o = hi;
               OP_MFLO:          ex_wdata_o = lo;
`endif
               default:          ex_wdata_o = '0;
            endcase
         end
         default: ex_wdata_o = '0;
      endcase

`ifndef MOVE_OP_EN
      // Without HI/LO the reads have nothing to return and must not write back.
      if (aluop_i == OP_MFHI || aluop_i == OP_MFLO) begin
         ex_wreg_o  = 1'b0;
         ex_wdata_o = '0;
      end
      if (aluop_i == OP_MTHI || aluop_i == OP_MTLO) ex_wdata_o = '0;
`endif

      if (rst) begin
         ex_wreg_o  = 1'b0;
         ex_wd_o    = '0;
         ex_wdata_o = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         mem_wreg_o  <= 1'b0;
         mem_wd_o    <= '0;
         mem_wdata_o <= '0;
      end else if (!stall_i) begin
         mem_wreg_o  <= ex_wreg_o;
         mem_wd_o    <= ex_wd_o;
         mem_wdata_o <= ex_wdata_o;
      end
   end

endmodule

// File: tb/tb_ex_hilo.sv
// Directed bench for ex_hilo: vector table for the EX datapath plus hand sequences
// for HI/LO forwarding, stall, flush and reset. Expectations follow MOVE_OP_EN.
module tb_ex_hilo;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        flush_i;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i;
   logic [31:0] reg2_i;
   logic [4:0]  wd_i;
   logic        wreg_i;
   logic        ex_wreg_o;
   logic [4:0]  ex_wd_o;
   logic [31:0] ex_wdata_o;
   logic        mem_wreg_o;
   logic [4:0]  mem_wd_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef MOVE_OP_EN
   localparam bit MOVE_EN = 1'b1;
`else
   localparam bit MOVE_EN = 1'b0;
`endif

   ex_hilo dut (
      .clk         (clk),
      .rst         (rst),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .aluop_i     (aluop_i),
      .alusel_i    (alusel_i),
      .reg1_i      (reg1_i),
      .reg2_i      (reg2_i),
      .wd_i        (wd_i),
      .wreg_i      (wreg_i),
      .ex_wreg_o   (ex_wreg_o),
      .ex_wd_o     (ex_wd_o),
      .ex_wdata_o  (ex_wdata_o),
      .mem_wreg_o  (mem_wreg_o),
      .mem_wd_o    (mem_wd_o),
      .mem_wdata_o (mem_wdata_o),
      .hi_o        (hi_o),
      .lo_o        (lo_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  alusel;
      logic [7:0]  aluop;
      logic [31:0] reg1;
      logic [31:0] reg2;
      logic [4:0]  wd;
      logic        wreg;
      logic        exp_wreg;
      logic [31:0] exp_wdata;
   } vec_t;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_tests++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
      alusel_i = sel;
      aluop_i  = op;
      reg1_i   = r1;
      reg2_i   = r2;
      wd_i     = wd;
      wreg_i   = wreg;
   endtask

   // Advance across one rising edge and sample 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_mem(input string tag, input logic wreg, input logic [4:0] wd, input logic [31:0] wdata);
      check({tag, "_mem_wreg"},  {31'd0, mem_wreg_o}, {31'd0, wreg});
      check({tag, "_mem_wd"},    {27'd0, mem_wd_o},   {27'd0, wd});
      check({tag, "_mem_wdata"}, mem_wdata_o,         wdata);
   endtask

   vec_t vecs[13];

   initial begin
      vecs[0]  = '{"ori",      3'd1, 8'h25, 32'h0000FFFF, 32'hFF000000, 5'd3,  1'b1, 1'b1, 32'hFF00FFFF};
      vecs[1]  = '{"and",      3'd1, 8'h24, 32'hF0F0F0F0, 32'hFF00FF00, 5'd4,  1'b1, 1'b1, 32'hF000F000};
      vecs[2]  = '{"xor",      3'd1, 8'h26, 32'hF0F0F0F0, 32'hFF00FF00, 5'd6,  1'b1, 1'b1, 32'h0FF00FF0};
      vecs[3]  = '{"nor",      3'd1, 8'h27, 32'h0000FFFF, 32'hFF000000, 5'd7,  1'b1, 1'b1, 32'h00FF0000};
      vecs[4]  = '{"sra",      3'd2, 8'h03, 32'd4,        32'h80000000, 5'd8,  1'b1, 1'b1, 32'hF8000000};
      vecs[5]  = '{"srl",      3'd2, 8'h02, 32'd4,        32'h80000000, 5'd9,  1'b1, 1'b1, 32'h08000000};
      vecs[6]  = '{"sll",      3'd2, 8'h7C, 32'd31,       32'd1,        5'd10, 1'b1, 1'b1, 32'h80000000};
      vecs[7]  = '{"sra_mask", 3'd2, 8'h03, 32'h00000024, 32'h7FFFFFFF, 5'd11, 1'b1, 1'b1, 32'h07FFFFFF};
      vecs[8]  = '{"movz",     3'd3, 8'h0A, 32'h12345678, 32'd0,        5'd12, 1'b1, 1'b1, 32'h12345678};
      vecs[9]  = '{"movn",     3'd3, 8'h0B, 32'hCAFEBABE, 32'd1,        5'd13, 1'b0, 1'b0, 32'hCAFEBABE};
      vecs[10] = '{"bad_pair", 3'd1, 8'h02, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd14, 1'b1, 1'b1, 32'h00000000};
      vecs[11] = '{"nop",      3'd0, 8'h00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 1'b1, 1'b1, 32'h00000000};
      vecs[12] = '{"bad_sel",  3'd5, 8'h25, 32'hFFFFFFFF, 32'h0,        5'd16, 1'b1, 1'b1, 32'h00000000};

      rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      drive(3'd1, 8'h25, 32'h0000FFFF, 32'hFF000000, 5'd3, 1'b1);
      tick();
      tick();
      check("rst_ex_wreg",  {31'd0, ex_wreg_o}, 32'd0);
      check("rst_ex_wd",    {27'd0, ex_wd_o},   32'd0);
      check("rst_ex_wdata", ex_wdata_o,         32'd0);
      check_mem("rst", 1'b0, 5'd0, 32'd0);
      check("rst_hi", hi_o, 32'd0);
      check("rst_lo", lo_o, 32'd0);

      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 13; i++) begin
         drive(vecs[i].alusel, vecs[i].aluop, vecs[i].reg1, vecs[i].reg2, vecs[i].wd, vecs[i].wreg);
         #1;
         check({vecs[i].name, "_ex_wdata"}, ex_wdata_o,         vecs[i].exp_wdata);
         check({vecs[i].name, "_ex_wreg"},  {31'd0, ex_wreg_o}, {31'd0, vecs[i].exp_wreg});
         check({vecs[i].name, "_ex_wd"},    {27'd0, ex_wd_o},   {27'd0, vecs[i].wd});
         tick();
         check_mem(vecs[i].name, vecs[i].exp_wreg, vecs[i].wd, vecs[i].exp_wdata);
         @(negedge clk);
      end

      // MTHI then MFHI back to back: the read sees the freshly written HI.
      drive(3'd0, 8'h11, 32'h12345678, 32'd0, 5'd0, 1'b0);
      tick();
      check("mthi_hi", hi_o, MOVE_EN ? 32'h12345678 : 32'd0);
      @(negedge clk);
      drive(3'd3, 8'h10, 32'd0, 32'd0, 5'd5, 1'b1);
      #1;
      check("mfhi_ex_wdata", ex_wdata_o,         MOVE_EN ? 32'h12345678 : 32'd0);
      check("mfhi_ex_wreg",  {31'd0, ex_wreg_o}, {31'd0, MOVE_EN});
      tick();
      check_mem("mfhi", MOVE_EN, 5'd5, MOVE_EN ? 32'h12345678 : 32'd0);

      // MTLO held by a two-cycle stall, then committed once the stall drops.
      @(negedge clk);
      drive(3'd0, 8'h13, 32'hA5A5A5A5, 32'd0, 5'd0, 1'b0);
      stall_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick();
         check("stall_lo", lo_o, 32'd0);
         check_mem("stall", MOVE_EN, 5'd5, MOVE_EN ? 32'h12345678 : 32'd0);
      end
      @(negedge clk);
      stall_i = 1'b0;
      tick();
      check("mtlo_lo", lo_o, MOVE_EN ? 32'hA5A5A5A5 : 32'd0);
      check_mem("mtlo", 1'b0, 5'd0, 32'd0);

      // Flush with stall over a pending MTHI yields a bubble and no HI write.
      @(negedge clk);
      drive(vecs[0].alusel, vecs[0].aluop, vecs[0].reg1, vecs[0].reg2, vecs[0].wd, vecs[0].wreg);
      tick();
      check_mem("pre_flush", 1'b1, 5'd3, 32'hFF00FFFF);
      @(negedge clk);
      drive(3'd0, 8'h11, 32'hDEAD0000, 32'd0, 5'd2, 1'b1);
      flush_i = 1'b1;
      stall_i = 1'b1;
      tick();
      check_mem("flush", 1'b0, 5'd0, 32'd0);
      check("flush_hi", hi_o, MOVE_EN ? 32'h12345678 : 32'd0);
      @(negedge clk);
      flush_i = 1'b0;
      stall_i = 1'b0;

      // HI=1, then reset alongside another MTHI discards both.
      drive(3'd0, 8'h11, 32'h00000001, 32'd0, 5'd9, 1'b1);
      tick();
      check("hi_one", hi_o, MOVE_EN ? 32'h1 : 32'd0);
      @(negedge clk);
      drive(3'd0, 8'h11, 32'h00000077, 32'd0, 5'd9, 1'b1);
      rst = 1'b1;
      tick();
      check("rst2_hi", hi_o, 32'd0);
      check("rst2_lo", lo_o, 32'd0);
      check_mem("rst2", 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(3'd3, 8'h10, 32'd0, 32'd0, 5'd5, 1'b1);
      #1;
      check("mfhi_post_rst_wdata", ex_wdata_o,         32'd0);
      check("mfhi_post_rst_wreg",  {31'd0, ex_wreg_o}, {31'd0, MOVE_EN});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
